// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory fetch sequencer.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W    = 8;
  localparam int unsigned INST_W         = 32;
  localparam int unsigned BYTES_PER_INST = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Arbitrates the byte-wide instruction memory between the IF stage and the program loader,
// assembling four sequential byte reads into one big-endian instruction word.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [INST_W-1:0] fetch_inst,
  output logic              fetch_misaligned,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] LastK = 2'(BYTES_PER_INST - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // fetch base or loader address
  logic [7:0]        data_q, data_d;
  logic [1:0]        k_q, k_d;
  logic [INST_W-1:0] asm_q, asm_d;
  logic [INST_W-1:0] inst_q, inst_d;

  // Upper PC bits and the byte shifted out of the assembly register are dropped by design.
  logic unused_bits;
  assign unused_bits = ^{fetch_pc[31:ADDR_W], asm_q[INST_W-1:INST_W-8]};

  assign fetch_inst = inst_q;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    k_d              = k_q;
    asm_d            = asm_q;
    inst_d           = inst_q;
    fetch_ready      = 1'b0;
    load_ready       = 1'b0;
    fetch_valid      = 1'b0;
    fetch_misaligned = 1'b0;
    mem_addr         = '0;
    mem_we           = 1'b0;
    mem_wdata        = '0;

    unique case (state_q)
      StIdle: begin
        load_ready  = 1'b1;
        fetch_ready = !load_valid;
        if (load_valid) begin
          addr_d  = load_addr;
          data_d  = load_data;
          state_d = StWrite;
        end else if (fetch_req) begin
          addr_d  = fetch_pc[ADDR_W-1:0];
          k_d     = 2'd0;
          state_d = StRead;
        end
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        state_d   = StIdle;
      end
      StRead: begin
        mem_addr = addr_q + ADDR_W'(k_q);
        // Read data lags the address by one cycle, so byte k-1 arrives while issuing byte k.
        if (k_q != 2'd0) begin
          asm_d = {asm_q[INST_W-9:0], mem_rdata};
        end
        k_d = k_q + 2'd1;
        if (k_q == LastK) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        asm_d   = {asm_q[INST_W-9:0], mem_rdata};
        inst_d  = {asm_q[INST_W-9:0], mem_rdata};
        state_d = StDone;
      end
      StDone: begin
        fetch_valid      = 1'b1;
        fetch_misaligned = |addr_q[1:0];
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
      inst_q  <= inst_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed loads and fetches against a byte memory model.
module tb_imem_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready, fetch_valid, fetch_misaligned;
  logic [31:0] fetch_inst;
  logic        load_valid = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  typedef struct packed {
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  mem [256];
  logic        mem_clr = 1'b1;

  imem_fetch_ctrl #(.ADDR_W(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_req        (fetch_req),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .fetch_valid      (fetch_valid),
    .fetch_inst       (fetch_inst),
    .fetch_misaligned (fetch_misaligned),
    .load_valid       (load_valid),
    .load_addr        (load_addr),
    .load_data        (load_data),
    .load_ready       (load_ready),
    .mem_addr         (mem_addr),
    .mem_we           (mem_we),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clock = ~clock;

  // Registered-read byte memory.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every fetch_valid pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (fetch_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetch_valid", 32'(fetch_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("fetch_inst", fetch_inst, mon_e.inst);
        check("fetch_misaligned", 32'(fetch_misaligned), 32'(mon_e.mis));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    check("load_ready_idle", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    check("load_mem_we", 32'(mem_we), 32'd1);
    check("load_mem_addr", 32'(mem_addr), 32'(a));
    check("load_mem_wdata", 32'(mem_wdata), 32'(d));
    tick();
  endtask

  // Called in the cycle after the fetch was accepted; leaves the DUT back in idle.
  task automatic fetch_body(input logic [31:0] pc);
    int i;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ea;
      ea = pc[7:0] + 8'(k);
      check("fetch_mem_addr", 32'(mem_addr), 32'(ea));
      if (k < 3) tick();
    end
    i = 0;
    do begin
      tick();
      i++;
    end while (!fetch_valid && i < 12);
    check("fetch_valid_latency", 32'(i), 32'd2);
    tick();
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] einst, input logic emis);
    exp_q.push_back({einst, emis});
    fetch_req = 1'b1;
    fetch_pc  = pc;
    #1;
    check("fetch_ready_idle", 32'(fetch_ready), 32'd1);
    tick();
    fetch_req = 1'b0;
    fetch_body(pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    tick();
    tick();
    reset   = 1'b0;
    mem_clr = 1'b0;
    #1;
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_inst", fetch_inst, 32'd0);
    check("rst_fetch_misaligned", 32'(fetch_misaligned), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_load_ready", 32'(load_ready), 32'd1);

    load_byte(8'd0, 8'h00); load_byte(8'd1, 8'h40); load_byte(8'd2, 8'h01); load_byte(8'd3, 8'h13);
    do_fetch(32'd0, 32'h0040_0113, 1'b0);

    load_byte(8'd16, 8'h00); load_byte(8'd17, 8'hC1);
    load_byte(8'd18, 8'h0F); load_byte(8'd19, 8'hE7);
    do_fetch(32'd16, 32'h00C1_0FE7, 1'b0);

    // Address wrap, misaligned base, and ignored upper PC bits.
    load_byte(8'd254, 8'hAA); load_byte(8'd255, 8'hBB);
    load_byte(8'd0, 8'hCC); load_byte(8'd1, 8'hDD);
    do_fetch(32'd254, 32'hAABB_CCDD, 1'b1);
    do_fetch(32'h100, 32'hCCDD_0113, 1'b0);
    do_fetch(32'hABCD_0013, 32'hE700_0000, 1'b1);

    // Contention: loader wins, fetch accepted two cycles later.
    exp_q.push_back({32'h5A00_0000, 1'b0});
    load_valid = 1'b1; load_addr = 8'd32; load_data = 8'h5A;
    fetch_req  = 1'b1; fetch_pc  = 32'd32;
    #1;
    check("contend_fetch_ready", 32'(fetch_ready), 32'd0);
    check("contend_load_ready", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    check("contend_mem_we", 32'(mem_we), 32'd1);
    check("contend_mem_addr", 32'(mem_addr), 32'd32);
    check("contend_busy_fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    check("contend_fetch_ready_after", 32'(fetch_ready), 32'd1);
    tick();
    fetch_req = 1'b0;
    fetch_body(32'd32);

    // Loader arrives mid-fetch: held off until idle, fetched word unaffected.
    exp_q.push_back({32'hCCDD_0113, 1'b0});
    fetch_req = 1'b1; fetch_pc = 32'd0;
    #1;
    tick();
    fetch_req = 1'b0;
    tick();
    load_valid = 1'b1; load_addr = 8'd2; load_data = 8'h77;
    for (int c = 2; c <= 7; c++) begin
      #1;
      check("busy_load_ready", 32'(load_ready), (c == 7) ? 32'd1 : 32'd0);
      if (c < 7) tick();
    end
    check("busy_idle_fetch_ready", 32'(fetch_ready), 32'd0);
    tick();
    load_valid = 1'b0;
    check("late_load_mem_we", 32'(mem_we), 32'd1);
    check("late_load_mem_addr", 32'(mem_addr), 32'd2);
    tick();
    do_fetch(32'd0, 32'hCCDD_7713, 1'b0);

    // Reset in cycle N+3 of a fetch aborts it.
    fetch_req = 1'b1; fetch_pc = 32'd16;
    #1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_fetch_ready", 32'(fetch_ready), 32'd1);
    check("abort_fetch_inst", fetch_inst, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= fetch_valid;
    end
    check("abort_no_valid", 32'(seen), 32'd0);

    // Reset during a write drops back to idle.
    load_valid = 1'b1; load_addr = 8'd40; load_data = 8'h99;
    tick();
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wr_abort_mem_we", 32'(mem_we), 32'd0);
    check("wr_abort_load_ready", 32'(load_ready), 32'd1);
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
